// File: rtl/decode_queue_if.sv
// Decode-queue types and the fetch/EX-facing signal bundle.
package decode_queue_pkg;
    typedef logic [31:0] rv32i_word;
    typedef logic [31:0] rv32i_inst_t;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic { alumux1_rs1_out = 1'b0, alumux1_pc_out = 1'b1 } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm = 3'd0, alumux2_u_imm = 3'd1, alumux2_b_imm = 3'd2,
        alumux2_s_imm = 3'd3, alumux2_j_imm = 3'd4, alumux2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic { cmpmux_rs2_out = 1'b0, cmpmux_i_imm = 1'b1 } cmpmux_sel_t;

    typedef enum logic [3:0] {
        rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw = 4'd3, rf_pc_plus4 = 4'd4,
        rf_lb = 4'd5, rf_lbu = 4'd6, rf_lh = 4'd7, rf_lhu = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        alu_ops         aluop;
        alumux1_sel_t   alumux1_sel;
        alumux2_sel_t   alumux2_sel;
        cmpmux_sel_t    cmpmux_sel;
        branch_funct3_t cmpop;
        logic           is_branch;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] store_funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic            load_regfile;
        regfilemux_sel_t regfilemux_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic       valid;
        rv32i_word  pc;
        logic [6:0] opcode;
        ex_ctrl_t   ex;
        mem_ctrl_t  mem;
        wb_ctrl_t   wb;
    } ctrl_word_t;
endpackage

// Fetch-side and EX-side handshakes plus flush. The slave modport is the
// queue itself; master is the surrounding pipeline (fetch + EX).
interface decode_queue_if #(parameter int DEPTH = 2);
    import decode_queue_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    rv32i_word                    in_pc;
    rv32i_inst_t                  in_instr;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    ctrl_word_t                   out_ctrl;
    logic [4:0]                   out_rs1;
    logic [4:0]                   out_rs2;
    logic [4:0]                   out_rd;
    logic                         out_illegal;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_rd, out_illegal, occupancy
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_rd, out_illegal, occupancy
    );
endinterface

// File: rtl/decode_queue.sv
// Registered ID-stage decoder: decodes fetched (pc, instr) pairs and buffers
// them in an in-order FIFO toward EX, with single-cycle flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_queue_if.slave dq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        ctrl_word_t ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = dq.in_instr[6:0];
    assign funct3 = dq.in_instr[14:12];
    assign funct7 = dq.in_instr[31:25];

    ctrl_word_t dec_ctrl;
    logic       dec_illegal;
    entry_t     wr_entry;

    // Decode the incoming instruction into its control word and legality.
    always_comb begin
        dec_ctrl        = '0;
        dec_illegal     = 1'b0;
        dec_ctrl.valid  = 1'b1;
        dec_ctrl.pc     = dq.in_pc;
        dec_ctrl.opcode = opcode;
        case (opcode)
            op_lui: begin
                dec_ctrl.wb.load_regfile   = 1'b1;
                dec_ctrl.wb.regfilemux_sel = rf_u_imm;
            end
            op_auipc: begin
                dec_ctrl.ex.alumux1_sel    = alumux1_pc_out;
                dec_ctrl.ex.alumux2_sel    = alumux2_u_imm;
                dec_ctrl.ex.aluop          = alu_add;
                dec_ctrl.wb.load_regfile   = 1'b1;
                dec_ctrl.wb.regfilemux_sel = rf_alu_out;
            end
            op_jal: begin
                dec_ctrl.ex.alumux1_sel    = alumux1_pc_out;
                dec_ctrl.ex.alumux2_sel    = alumux2_j_imm;
                dec_ctrl.wb.load_regfile   = 1'b1;
                dec_ctrl.wb.regfilemux_sel = rf_pc_plus4;
            end
            op_jalr: begin
                dec_ctrl.ex.alumux1_sel    = alumux1_rs1_out;
                dec_ctrl.ex.alumux2_sel    = alumux2_i_imm;
                dec_ctrl.wb.load_regfile   = 1'b1;
                dec_ctrl.wb.regfilemux_sel = rf_pc_plus4;
                dec_illegal                = (funct3 != 3'b000);
            end
            op_br: begin
                dec_ctrl.ex.alumux1_sel = alumux1_pc_out;
                dec_ctrl.ex.alumux2_sel = alumux2_b_imm;
                dec_ctrl.ex.aluop       = alu_add;
                dec_ctrl.ex.cmpmux_sel  = cmpmux_rs2_out;
                dec_ctrl.ex.cmpop       = branch_funct3_t'(funct3);
                dec_ctrl.ex.is_branch   = 1'b1;
                dec_illegal             = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            op_store: begin
                dec_ctrl.ex.alumux2_sel   = alumux2_s_imm;
                dec_ctrl.mem.mem_write    = 1'b1;
                dec_ctrl.mem.store_funct3 = funct3;
                dec_illegal               = (funct3 > 3'b010);
            end
            op_load: begin
                dec_ctrl.ex.alumux2_sel  = alumux2_i_imm;
                dec_ctrl.mem.mem_read    = 1'b1;
                dec_ctrl.wb.load_regfile = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl.wb.regfilemux_sel = rf_lb;
                    3'b001:  dec_ctrl.wb.regfilemux_sel = rf_lh;
                    3'b010:  dec_ctrl.wb.regfilemux_sel = rf_lw;
                    3'b100:  dec_ctrl.wb.regfilemux_sel = rf_lbu;
                    3'b101:  dec_ctrl.wb.regfilemux_sel = rf_lhu;
                    default: dec_illegal = 1'b1;
                endcase
            end
            op_imm, op_reg: begin
                dec_ctrl.wb.load_regfile = 1'b1;
                case (funct3)
                    3'b010, 3'b011: begin
                        // Set-less-than is resolved by the comparator, not the ALU.
                        dec_ctrl.ex.cmpmux_sel     = (opcode == op_reg) ? cmpmux_rs2_out : cmpmux_i_imm;
                        dec_ctrl.ex.cmpop          = funct3[0] ? bltu : blt;
                        dec_ctrl.wb.regfilemux_sel = rf_br_en;
                    end
                    3'b101:  dec_ctrl.ex.aluop = funct7[5] ? alu_sra : alu_srl;
                    3'b000:  dec_ctrl.ex.aluop = (opcode == op_reg && funct7[5]) ? alu_sub : alu_add;
                    default: dec_ctrl.ex.aluop = alu_ops'(funct3);
                endcase
                if (opcode == op_reg) begin
                    if (funct3 != 3'b010 && funct3 != 3'b011)
                        dec_ctrl.ex.alumux2_sel = alumux2_rs2_out;
                    if (funct3 == 3'b101)
                        dec_ctrl.wb.regfilemux_sel = rf_alu_out;
                    dec_illegal = (funct7 != 7'h00 && funct7 != 7'h20) ||
                                  (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101);
                end else begin
                    dec_illegal = (funct3 == 3'b001 && funct7 != 7'h00) ||
                                  (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Form the stored entry: illegal entries keep only pc/opcode; unused indices are zeroed.
    always_comb begin
        wr_entry = '0;
        if (dec_illegal) begin
            wr_entry.ctrl.pc     = dq.in_pc;
            wr_entry.ctrl.opcode = opcode;
            wr_entry.illegal     = 1'b1;
        end else begin
            wr_entry.ctrl = dec_ctrl;
            wr_entry.rd   = (opcode == op_br || opcode == op_store) ? 5'd0 : dq.in_instr[11:7];
            wr_entry.rs1  = (opcode == op_lui || opcode == op_auipc || opcode == op_jal)
                            ? 5'd0 : dq.in_instr[19:15];
            wr_entry.rs2  = (opcode == op_reg || opcode == op_br || opcode == op_store)
                            ? dq.in_instr[24:20] : 5'd0;
        end
    end

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;

    // in_ready depends only on the registered count, so a full queue frees a
    // slot one cycle after the pop rather than through a ready->ready path.
    assign dq.in_ready  = (count_q < CNT_W'(DEPTH));
    assign dq.out_valid = (count_q != '0);
    assign push = dq.in_valid && dq.in_ready && !dq.flush && (ILLEGAL_TRAP || !dec_illegal);
    assign pop  = dq.out_valid && dq.out_ready && !dq.flush;

    // Next-state for pointers and count; flush overrides any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (dq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the write pointer on each push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign dq.out_ctrl    = mem_q[rd_ptr_q].ctrl;
    assign dq.out_rs1     = mem_q[rd_ptr_q].rs1;
    assign dq.out_rs2     = mem_q[rd_ptr_q].rs2;
    assign dq.out_rd      = mem_q[rd_ptr_q].rd;
    assign dq.out_illegal = mem_q[rd_ptr_q].illegal;
    assign dq.occupancy   = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed cases plus randomized traffic.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] ADDI  = 32'h0051_0093;
    localparam logic [31:0] SUB   = 32'h4020_81B3;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef struct packed {
        ctrl_word_t ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_queue_if #(.DEPTH(DEPTH)) dq ();
    decode_queue_if #(.DEPTH(4))     dq0 ();

    decode_queue #(.DEPTH(DEPTH), .ILLEGAL_TRAP(1'b1)) dut  (.clk(clk), .rst(rst), .dq(dq));
    decode_queue #(.DEPTH(4),     .ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .dq(dq0));

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [31:0] popped_pc[$];
    bit rdy_snap;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        case (op)
            op_lui, op_auipc, op_jal: return 1'b1;
            op_jalr:  return f3 == 3'd0;
            op_br:    return !(f3 == 3'd2 || f3 == 3'd3);
            op_load:  return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            op_store: return f3 <= 3'd2;
            op_reg:   return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            op_imm: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
                return 1'b1;
            end
            default:  return 1'b0;
        endcase
    endfunction

    // Reference decoder written directly from the opcode/format rules.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        bit rr;
        op = ins[6:0]; f3 = ins[14:12]; rr = (op == op_reg);
        e = '0;
        e.ctrl.pc = pc;
        e.ctrl.opcode = op;
        if (!is_legal(ins)) begin
            e.ill = 1'b1;
            return e;
        end
        e.ctrl.valid = 1'b1;
        e.rd  = (op == op_br || op == op_store) ? 5'd0 : ins[11:7];
        e.rs1 = (op == op_lui || op == op_auipc || op == op_jal) ? 5'd0 : ins[19:15];
        e.rs2 = (op == op_reg || op == op_br || op == op_store) ? ins[24:20] : 5'd0;
        e.ctrl.wb.load_regfile = !(op == op_br || op == op_store);
        case (op)
            op_lui:   e.ctrl.wb.regfilemux_sel = rf_u_imm;
            op_auipc: begin
                e.ctrl.ex.alumux1_sel = alumux1_pc_out;
                e.ctrl.ex.alumux2_sel = alumux2_u_imm;
            end
            op_jal: begin
                e.ctrl.ex.alumux1_sel = alumux1_pc_out;
                e.ctrl.ex.alumux2_sel = alumux2_j_imm;
                e.ctrl.wb.regfilemux_sel = rf_pc_plus4;
            end
            op_jalr:  e.ctrl.wb.regfilemux_sel = rf_pc_plus4;
            op_br: begin
                e.ctrl.ex.alumux1_sel = alumux1_pc_out;
                e.ctrl.ex.alumux2_sel = alumux2_b_imm;
                e.ctrl.ex.cmpop = branch_funct3_t'(f3);
                e.ctrl.ex.is_branch = 1'b1;
            end
            op_store: begin
                e.ctrl.ex.alumux2_sel = alumux2_s_imm;
                e.ctrl.mem.mem_write = 1'b1;
                e.ctrl.mem.store_funct3 = f3;
            end
            op_load: begin
                e.ctrl.mem.mem_read = 1'b1;
                if (f3 == 3'd0) e.ctrl.wb.regfilemux_sel = rf_lb;
                if (f3 == 3'd1) e.ctrl.wb.regfilemux_sel = rf_lh;
                if (f3 == 3'd2) e.ctrl.wb.regfilemux_sel = rf_lw;
                if (f3 == 3'd4) e.ctrl.wb.regfilemux_sel = rf_lbu;
                if (f3 == 3'd5) e.ctrl.wb.regfilemux_sel = rf_lhu;
            end
            default: begin // op_imm / op_reg
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    e.ctrl.ex.cmpmux_sel = rr ? cmpmux_rs2_out : cmpmux_i_imm;
                    e.ctrl.ex.cmpop = (f3 == 3'd2) ? blt : bltu;
                    e.ctrl.wb.regfilemux_sel = rf_br_en;
                end else begin
                    e.ctrl.ex.alumux2_sel = rr ? alumux2_rs2_out : alumux2_i_imm;
                    if (f3 == 3'd5)             e.ctrl.ex.aluop = ins[30] ? alu_sra : alu_srl;
                    else if (f3 == 3'd0 && rr && ins[30]) e.ctrl.ex.aluop = alu_sub;
                    else                        e.ctrl.ex.aluop = alu_ops'(f3);
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(7) == 0) return w;
        w[6:0] = ops[$urandom_range(9)];
        case ($urandom_range(3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // Monitor: compares handshake state and head entry against the scoreboard.
    always @(negedge clk) begin
        rdy_snap = (exp_q.size() < DEPTH);
        chk("in_ready", 128'(dq.in_ready), 128'(rdy_snap));
        chk("out_valid", 128'(dq.out_valid), 128'(exp_q.size() != 0));
        chk("occupancy", 128'(dq.occupancy), 128'(exp_q.size()));
        if (dq.out_valid && exp_q.size() != 0) begin
            chk("head_entry", 128'({dq.out_ctrl, dq.out_rs1, dq.out_rs2, dq.out_rd, dq.out_illegal}),
                128'(exp_q[0]));
            if (dq.out_ready && !dq.flush) begin
                popped_pc.push_back(dq.out_ctrl.pc);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; the expected entry is queued when the handshake will complete.
    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl);
        @(posedge clk); #1;
        dq.in_valid = v; dq.in_pc = pc; dq.in_instr = ins; dq.out_ready = ordy; dq.flush = fl;
        @(negedge clk); #2;
        if (fl) exp_q.delete();
        else if (v && rdy_snap) exp_q.push_back(model(pc, ins));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        dq.in_valid = 0; dq.in_pc = 0; dq.in_instr = 0; dq.out_ready = 0; dq.flush = 0;
        dq0.in_valid = 0; dq0.in_pc = 0; dq0.in_instr = 0; dq0.out_ready = 0; dq0.flush = 0;
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", 128'(dq.out_valid), 128'(0));
        chk("rst_in_ready", 128'(dq.in_ready), 128'(1));
        chk("rst_occupancy", 128'(dq.occupancy), 128'(0));
        chk("rst_out_ctrl", 128'(dq.out_ctrl), 128'(0));
        chk("rst_regs", 128'({dq.out_rs1, dq.out_rs2, dq.out_rd, dq.out_illegal}), 128'(0));
        @(posedge clk); @(posedge clk); #2 rst = 1'b1;

        // addi x1,x2,5
        drive(1, 32'h60, ADDI, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("addi_valid", 128'(dq.out_valid), 128'(1));
        chk("addi_pc", 128'(dq.out_ctrl.pc), 128'(32'h60));
        chk("addi_aluop", 128'(dq.out_ctrl.ex.aluop), 128'(alu_add));
        chk("addi_mux2", 128'(dq.out_ctrl.ex.alumux2_sel), 128'(alumux2_i_imm));
        chk("addi_ldrf", 128'(dq.out_ctrl.wb.load_regfile), 128'(1));
        chk("addi_rfmux", 128'(dq.out_ctrl.wb.regfilemux_sel), 128'(rf_alu_out));
        chk("addi_idx", 128'({dq.out_rd, dq.out_rs1, dq.out_rs2}), 128'({5'd1, 5'd2, 5'd0}));
        chk("addi_occ", 128'(dq.occupancy), 128'(1));
        drive(0, 0, 0, 1, 0);

        // sub x3,x1,x2
        drive(1, 32'h64, SUB, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("sub_aluop", 128'(dq.out_ctrl.ex.aluop), 128'(alu_sub));
        chk("sub_mux2", 128'(dq.out_ctrl.ex.alumux2_sel), 128'(alumux2_rs2_out));
        chk("sub_idx", 128'({dq.out_rd, dq.out_rs1, dq.out_rs2}), 128'({5'd3, 5'd1, 5'd2}));
        chk("sub_illegal", 128'(dq.out_illegal), 128'(0));
        drive(0, 0, 0, 1, 0);

        // ecall is illegal and trapped
        drive(1, 32'h68, ECALL, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("ecall_illegal", 128'(dq.out_illegal), 128'(1));
        chk("ecall_ctrl_valid", 128'(dq.out_ctrl.valid), 128'(0));
        chk("ecall_idx", 128'({dq.out_rd, dq.out_rs1, dq.out_rs2}), 128'(0));
        drive(0, 0, 0, 1, 0);

        // backpressure and in-order drain
        popped_pc.delete();
        drive(1, 32'h0, ADDI, 0, 0);
        drive(1, 32'h4, ADDI, 0, 0);
        drive(1, 32'h8, ADDI, 0, 0);
        chk("bp_in_ready", 128'(dq.in_ready), 128'(0));
        chk("bp_occ", 128'(dq.occupancy), 128'(2));
        drive(1, 32'h8, ADDI, 1, 0);
        drive(1, 32'h8, ADDI, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
        chk("bp_pop_count", 128'(popped_pc.size()), 128'(3));
        if (popped_pc.size() == 3) begin
            chk("bp_order", 128'({popped_pc[0], popped_pc[1], popped_pc[2]}),
                128'({32'h0, 32'h4, 32'h8}));
        end

        // flush with a same-cycle input
        drive(1, 32'h10, ADDI, 0, 0);
        drive(1, 32'h14, SUB, 0, 0);
        drive(1, 32'h18, ADDI, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("flush_valid", 128'(dq.out_valid), 128'(0));
        chk("flush_occ", 128'(dq.occupancy), 128'(0));
        chk("flush_in_ready", 128'(dq.in_ready), 128'(1));

        // asynchronous reset with two entries held
        drive(1, 32'h20, ADDI, 0, 0);
        drive(1, 32'h24, ADDI, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", 128'(dq.out_valid), 128'(0));
        chk("arst_in_ready", 128'(dq.in_ready), 128'(1));
        chk("arst_occ", 128'(dq.occupancy), 128'(0));
        @(posedge clk); #2 rst = 1'b1;
        drive(1, 32'h100, ADDI, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("arst_push_valid", 128'(dq.out_valid), 128'(1));
        chk("arst_push_pc", 128'(dq.out_ctrl.pc), 128'(32'h100));
        drive(0, 0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(9) < 7, $urandom() & 32'hFFFF_FFFC, rand_instr(),
                  $urandom_range(9) < 6, $urandom_range(32) == 0);
        end
        for (int i = 0; i < DEPTH + 3; i++) drive(0, 0, 0, 1, 0);

        // non-trapping instance: illegal input is accepted and dropped
        @(posedge clk); #1;
        dq0.in_valid = 1; dq0.in_pc = 32'h300; dq0.in_instr = ECALL; dq0.out_ready = 1;
        @(negedge clk);
        chk("drop_in_ready", 128'(dq0.in_ready), 128'(1));
        @(posedge clk); #1;
        dq0.in_valid = 0;
        @(negedge clk);
        chk("drop_valid", 128'(dq0.out_valid), 128'(0));
        chk("drop_occ", 128'(dq0.occupancy), 128'(0));
        @(posedge clk); #1;
        dq0.in_valid = 1; dq0.in_pc = 32'h304; dq0.in_instr = ADDI;
        @(posedge clk); #1;
        dq0.in_valid = 0;
        @(negedge clk);
        chk("drop_next_valid", 128'(dq0.out_valid), 128'(1));
        chk("drop_next_pc", 128'(dq0.out_ctrl.pc), 128'(32'h304));
        chk("drop_next_occ", 128'(dq0.occupancy), 128'(1));
        chk("drop_next_illegal", 128'(dq0.out_illegal), 128'(0));
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised, registered successor to the combinational instruction decoder in the ID stage. It accepts fetched (pc, instruction) pairs over a valid/ready handshake and decodes each one into a `ctrl_word_t` plus register indices and an illegal-instruction flag. Decoded entries are held in a DEPTH-entry in-order FIFO that feeds EX over a second valid/ready handshake, with a single-cycle flush for branch redirects.

## Interface
- `DEPTH`, default 2: number of buffer entries; must be a power of 2 and at least 2.
- `ILLEGAL_TRAP`, default 1: controls illegal-instruction handling.
  - 1: an illegal instruction is enqueued with `out_illegal`=1.
  - 0: an illegal instruction is accepted and silently dropped.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  the queue can accept an instruction.
- `in_pc`  in  32  PC of the instruction (`rv32i_word`).
- `in_instr`  in  32  instruction word (`rv32i_inst_t`).
- `flush`  in  1  discard all entries, plus any input in the same cycle.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  EX consumes the head entry.
- `out_ctrl`  out  `$bits(ctrl_word_t)`  decoded control word for the head entry.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices; 0 when the format does not use that field.
- `out_illegal`  out  1  the head entry is an illegal instruction.
- `occupancy`  out  `$clog2(DEPTH+1)`  number of valid entries.

## Operation
- **Push**: a push happens when `in_valid && in_ready && !flush` (and, for an illegal instruction with `ILLEGAL_TRAP`=0, no push occurs).
- **Pop**: a pop happens when `out_valid && out_ready && !flush`.
- **Decoding** is combinational on the input side, before the write. Stored fields:
  - `ctrl.valid`=1 and `ctrl.pc`=`in_pc`.
  - `ctrl.opcode`=`instr[6:0]`.
  - EX/MEM/WB control words, which start at all-zero.
- **Per-opcode encodings**:
  - `op_lui`: load_regfile; regfilemux `u_imm`.
  - `op_auipc`: pc_out + u_imm, `alu_add`; regfilemux `alu_out`.
  - `op_jal`: pc_out + j_imm; regfilemux `pc_plus4`.
  - `op_jalr`: rs1_out + i_imm; regfilemux `pc_plus4`.
  - `op_br`: pc_out + b_imm, `alu_add`; cmpmux `rs2_out`; cmpop=funct3; `is_branch`=1.
  - `op_store`: rs1_out + s_imm; `mem_write`=1; `store_funct3`=funct3.
  - `op_load`: rs1_out + i_imm; `mem_read`=1; load_regfile; regfilemux selects `lw`/`lh`/`lhu`/`lb`/`lbu` by funct3.
  - `op_imm`:
    - slt/sltu → cmpmux `i_imm`, cmpop `blt`/`bltu`, regfilemux `br_en`.
    - sr → `alu_srl`, or `alu_sra` if funct7[5].
    - everything else → `alu_ops'(funct3)` with `i_imm`.
  - `op_reg`: same as `op_imm`, with these differences:
    - the operand is rs2_out;
    - add with funct7[5] → `alu_sub`;
    - sr also sets regfilemux `alu_out`.
- **Illegal conditions** (any one makes the instruction illegal):
  - opcode is not one of the nine supported (this includes `op_csr`);
  - load funct3 ∈ {011,110,111};
  - store funct3 > 010;
  - branch funct3 ∈ {010,011};
  - jalr funct3 ≠ 000;
  - `op_reg` funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000,101};
  - `op_imm` slli with funct7 ≠ 0, or srli/srai with funct7 ∉ {0000000, 0100000}.
- **Illegal entry contents**: `ctrl` = all-zero except pc and opcode (so `ctrl.valid`=0), all register indices = 0, `out_illegal`=1.
- **Register index zeroing**:
  - rd = 0 for branch and store;
  - rs1 = 0 for lui, auipc and jal;
  - rs2 = 0 unless the opcode is op_reg, op_br or op_store.
- **FIFO structure**: `$clog2(DEPTH)`-bit read and write pointers that wrap naturally, plus a separate count.
  - `in_ready` = (count < DEPTH). It is a function of registered state only; there is no combinational path from `out_ready`.
  - A push and a pop in the same cycle leave the count unchanged. When the queue is full, a pop frees the slot only in the following cycle.
- **Flush**: count ← 0 and both pointers ← 0. A same-cycle push and pop are both ignored.

## Timing
- **Reset values** (asynchronous on `rst`=0, held until release):
  - count, pointers and all storage = 0;
  - `out_valid`=0, `in_ready`=1, `occupancy`=0;
  - `out_ctrl`=0, `out_rs*`/`out_rd`=0, `out_illegal`=0.
- **Reset mid-operation** drops all entries immediately, without waiting for a clock edge.
- **Latency**: a push into an empty queue in cycle N makes `out_valid`=1 with that entry's fields in cycle N+1.
- **Output stability**: outputs are driven from storage at the read pointer. The head fields stay stable while `out_valid && !out_ready`.
- **Ordering**: entries leave strictly in program order; there is no bypass.
- **Flush timing**: flush in cycle N gives `out_valid`=0, `occupancy`=0 and `in_ready`=1 in cycle N+1.

## Test plan
- **addi**: reset, then push `addi x1,x2,5` (0x00510093, pc 0x60) into the empty queue with `out_ready`=1.
  - Next cycle: `out_valid`=1, pc=0x60, `alu_add`, i_imm, load_regfile=1, regfilemux `alu_out`.
  - Indices rd=1, rs1=2, rs2=0; `occupancy`=1. The entry pops the following cycle.
- **sub**: push `sub x3,x1,x2` (0x402081B3).
  - Output shows `alu_sub`, alumux2 `rs2_out`, rd=3, rs1=1, rs2=2, `out_illegal`=0.
- **Illegal**: push 0x00000073 (ecall).
  - With `ILLEGAL_TRAP`=1: `out_illegal`=1, `ctrl.valid`=0, rd=rs1=rs2=0.
  - With `ILLEGAL_TRAP`=0: `out_valid` stays 0 and `occupancy` stays 0.
- **Backpressure** (`DEPTH`=2, `out_ready`=0): push pc 0x0, 0x4, 0x8.
  - `in_ready`=0 after the second push and `occupancy`=2; the third push stalls.
  - Raise `out_ready`: outputs come out at 0x0, then 0x4, then 0x8, in order.
- **Flush**: with 2 entries and `in_valid`=1, assert `flush` for one cycle.
  - Next cycle: `out_valid`=0, `occupancy`=0; the same-cycle input is not enqueued.
- **Reset mid-operation**: drop `rst` mid-cycle while 2 entries are held.
  - `out_valid` goes to 0 and `in_ready` to 1 without a clock edge. After release, a new push appears one cycle later.
